block_unpack_fifo: RTL and testbench
====================================

BLOCK_UNPACK_FIFO -- requirements
Module: block_unpack_fifo

Interface
REQ-001 SHALL have parameter BLOCK_W, default 128, width of one written block in bits.
REQ-002 SHALL have parameter WORD_W, default 32, width of one read word in bits; BLOCK_W SHALL be an integer multiple of WORD_W (WORDS = BLOCK_W/WORD_W).
REQ-003 SHALL have parameter DEPTH, default 4, number of block slots (power of two, >= 2).
REQ-004 SHALL have parameter MSW_FIRST, default 1, which sets word order: 1 means the most-significant word is read first, 0 means the least-significant word is read first.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port n_rst, input, 1 bit; reset is asynchronous and active-low.
REQ-007 SHALL have port clear, input, 1 bit, synchronous flush.
REQ-008 SHALL have port write_en, input, 1 bit, block write request.
REQ-009 SHALL have port data_in, input, BLOCK_W bits, block to store.
REQ-010 SHALL have port read_en, input, 1 bit, word read request.
REQ-011 SHALL have port data_out, output, WORD_W bits, registered last word read.
REQ-012 SHALL have port fifo_empty, output, 1 bit, set when no unread word remains.
REQ-013 SHALL have port fifo_full, output, 1 bit, set when all DEPTH slots hold unread words.
REQ-014 SHALL have port word_count, output, clog2(DEPTH*WORDS+1) bits, total unread words.

Function
REQ-015 SHALL accept a write when write_en=1, fifo_full=0 and clear=0: data_in goes into the slot at the write pointer, and the write pointer advances modulo DEPTH.
REQ-016 SHALL accept a read when read_en=1, fifo_empty=0 and clear=0: the next word of the head block goes to data_out on the following edge (1-cycle latency), and data_out SHALL hold its value otherwise.
REQ-017 SHALL unpack each block as follows: with MSW_FIRST=1, word k of WORDS is data[BLOCK_W-1-k*WORD_W -: WORD_W]; with MSW_FIRST=0, it is data[k*WORD_W +: WORD_W].
REQ-018 SHALL free the head slot once the final word of a block is read, advancing the read pointer modulo DEPTH and resetting the word index to 0.
REQ-019 SHALL accept a simultaneous legal read and write in the same cycle: word_count changes by WORDS-1 and no data is lost.
REQ-020 SHALL judge full and empty on the current-cycle flags only: a write while full is dropped even with a concurrent read, and a read while empty is dropped even with a concurrent write.
REQ-021 SHALL leave all state unchanged on a dropped request.
REQ-022 SHALL compute fifo_full, fifo_empty and word_count as registered values that are consistent with the pointers and the word index after each edge.
REQ-023 SHALL, when clear=1, zero the pointers, the word index and word_count, set fifo_empty=1 and fifo_full=0, and keep data_out; clear overrides write_en and read_en.

Reset
REQ-024 SHALL, on n_rst=0, immediately set data_out=0, fifo_empty=1, fifo_full=0, word_count=0, zero the pointers and word index, and zero the slots.
REQ-025 SHALL, after reset is asserted mid-block, discard all partially read blocks, and the first read after a new write SHALL return word 0 of that block.

Configuration
REQ-026 SHALL, when FIFO_OUT_ERR_FLAGS_EN is defined, add output ports overflow and underflow (1 bit each, sticky); a dropped write sets overflow, a dropped read sets underflow, and both are cleared by n_rst or clear.
REQ-027 SHALL, when FIFO_OUT_ERR_FLAGS_EN is undefined, have neither the overflow/underflow ports nor their logic.

Structure
REQ-028 SHALL take default parameter values and the word-index helper function from shared package aes_fifo_pkg.
REQ-029 SHALL implement word selection in sub-module fifo_word_mux (inputs: block, index, MSW_FIRST; output: word).

Verification
REQ-030 SHALL cover: write 0x00112233_44556677_8899AABB_CCDDEEFF, then 4 reads -> data_out 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF, each one cycle after its read_en, and fifo_empty=1 after the last read.
REQ-031 SHALL cover: the same block with MSW_FIRST=0 -> data_out order 0xCCDDEEFF, 0x8899AABB, 0x44556677, 0x00112233.
REQ-032 SHALL cover: 4 writes with DEPTH=4 -> fifo_full=1 and word_count=16; a 5th write is dropped, and with FIFO_OUT_ERR_FLAGS_EN defined overflow=1.
REQ-033 SHALL cover: read on the last word of a slot together with a write while full -> the write is dropped, fifo_full drops to 0 on the next edge, and word_count=12.
REQ-034 SHALL cover: 2 blocks stored, 1 word read, then read_en and write_en together -> word_count 7 then 10, with pointer wrap checked over 9 blocks of traffic.
REQ-035 SHALL cover: n_rst pulsed low mid-block -> all outputs at reset values asynchronously, and the next write/read returns word 0.

Source files
------------

// File: rtl/aes_fifo_pkg.sv
// Shared defaults and word-offset helper for the block-in / word-out FIFO.
package aes_fifo_pkg;

    localparam int unsigned DefaultBlockW   = 128;
    localparam int unsigned DefaultWordW    = 32;
    localparam int unsigned DefaultDepth    = 4;
    localparam int unsigned DefaultMswFirst = 1;

    // Bit offset of the LSB of word idx inside a block, in read order.
    function automatic int unsigned word_lsb(input int unsigned idx, input int unsigned words,
                                             input int unsigned word_w, input bit msw_first);
        return msw_first ? (words - 1 - idx) * word_w : idx * word_w;
    endfunction

endpackage

// File: rtl/fifo_word_mux.sv
// Selects word idx_i of a block in the configured word order.
module fifo_word_mux
    import aes_fifo_pkg::*;
#(
    parameter int unsigned BLOCK_W   = DefaultBlockW,
    parameter int unsigned WORD_W    = DefaultWordW,
    parameter int unsigned MSW_FIRST = DefaultMswFirst,
    localparam int unsigned WORDS    = BLOCK_W / WORD_W,
    localparam int unsigned IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic [BLOCK_W-1:0] block_i,
    input  logic [IDX_W-1:0]   idx_i,
    output logic [WORD_W-1:0]  word_o
);

    always_comb begin
        word_o = '0;
        for (int unsigned k = 0; k < WORDS; k++) begin
            if (idx_i == IDX_W'(k)) begin
                word_o = block_i[word_lsb(k, WORDS, WORD_W, MSW_FIRST != 0) +: WORD_W];
            end
        end
    end

endmodule

// File: rtl/block_unpack_fifo.sv
// FIFO storing BLOCK_W-bit blocks and returning them one WORD_W word at a time.
// Optional sticky overflow/underflow flags are enabled by FIFO_OUT_ERR_FLAGS_EN.
module block_unpack_fifo
    import aes_fifo_pkg::*;
#(
    parameter int unsigned BLOCK_W   = DefaultBlockW,
    parameter int unsigned WORD_W    = DefaultWordW,
    parameter int unsigned DEPTH     = DefaultDepth,
    parameter int unsigned MSW_FIRST = DefaultMswFirst,
    localparam int unsigned WORDS    = BLOCK_W / WORD_W,
    localparam int unsigned CNT_W    = $clog2(DEPTH * WORDS + 1)
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               clear,
    input  logic               write_en,
    input  logic [BLOCK_W-1:0] data_in,
    input  logic               read_en,
    output logic [WORD_W-1:0]  data_out,
    output logic               fifo_empty,
    output logic               fifo_full,
    output logic [CNT_W-1:0]   word_count
`ifdef FIFO_OUT_ERR_FLAGS_EN
    ,
    output logic               overflow,
    output logic               underflow
`endif
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned BCNT_W = $clog2(DEPTH + 1);

    logic [BLOCK_W-1:0] slots_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [BCNT_W-1:0]  blk_cnt_q, blk_cnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               empty_q, empty_d, full_q, full_d;
    logic [WORD_W-1:0]  dout_q, dout_d, head_word;
    logic               wr_ok, rd_ok, last_word;

    fifo_word_mux #(
        .BLOCK_W  (BLOCK_W),
        .WORD_W   (WORD_W),
        .MSW_FIRST(MSW_FIRST)
    ) u_word_mux (
        .block_i(slots_q[rd_ptr_q]),
        .idx_i  (idx_q),
        .word_o (head_word)
    );

    // Acceptance is judged on the registered flags only.
    assign wr_ok     = write_en && !full_q && !clear;
    assign rd_ok     = read_en && !empty_q && !clear;
    assign last_word = (idx_q == IDX_W'(WORDS - 1));

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        idx_d     = idx_q;
        blk_cnt_d = blk_cnt_q;
        cnt_d     = cnt_q;
        dout_d    = dout_q;
        if (clear) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            idx_d     = '0;
            blk_cnt_d = '0;
            cnt_d     = '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_d  = wr_ptr_q + PTR_W'(1);
                blk_cnt_d = blk_cnt_d + BCNT_W'(1);
                cnt_d     = cnt_d + CNT_W'(WORDS);
            end
            if (rd_ok) begin
                dout_d = head_word;
                cnt_d  = cnt_d - CNT_W'(1);
                if (last_word) begin
                    idx_d     = '0;
                    rd_ptr_d  = rd_ptr_q + PTR_W'(1);
                    blk_cnt_d = blk_cnt_d - BCNT_W'(1);
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
        end
        empty_d = (cnt_d == '0);
        full_d  = (blk_cnt_d == BCNT_W'(DEPTH));
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            idx_q     <= '0;
            blk_cnt_q <= '0;
            cnt_q     <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            dout_q    <= '0;
        end else begin
            if (wr_ok) begin
                slots_q[wr_ptr_q] <= data_in;
            end
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            idx_q     <= idx_d;
            blk_cnt_q <= blk_cnt_d;
            cnt_q     <= cnt_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
            dout_q    <= dout_d;
        end
    end

    assign data_out   = dout_q;
    assign fifo_empty = empty_q;
    assign fifo_full  = full_q;
    assign word_count = cnt_q;

`ifdef FIFO_OUT_ERR_FLAGS_EN
    logic ovf_q, ovf_d, udf_q, udf_d;

    always_comb begin
        ovf_d = clear ? 1'b0 : (ovf_q || (write_en && full_q));
        udf_d = clear ? 1'b0 : (udf_q || (read_en && empty_q));
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = udf_q;
`endif

endmodule

// File: tb/tb_block_unpack_fifo.sv
// Directed bench for block_unpack_fifo: one MSW-first and one LSW-first instance, shared stimulus.
module tb_block_unpack_fifo;

    logic         clk = 1'b0;
    logic         n_rst = 1'b1;
    logic         clear = 1'b0;
    logic         write_en = 1'b0;
    logic [127:0] data_in = '0;
    logic         read_en = 1'b0;
    logic [31:0]  dout_m, dout_l;
    logic         empty_m, empty_l, full_m, full_l;
    logic [4:0]   cnt_m, cnt_l;
`ifdef FIFO_OUT_ERR_FLAGS_EN
    logic         ovf_m, udf_m, ovf_l, udf_l;
    bit           e_ovf, e_udf;
`endif

    int unsigned  n_pass = 0;
    int unsigned  n_total = 0;
    logic [31:0]  qm[$];
    logic [31:0]  ql[$];
    logic [31:0]  lm, ll;

    localparam logic [127:0] Blk = 128'h00112233_44556677_8899AABB_CCDDEEFF;

    always #5 clk = ~clk;

    block_unpack_fifo #(.BLOCK_W(128), .WORD_W(32), .DEPTH(4), .MSW_FIRST(1)) u_dut_m (
        .clk       (clk),
        .n_rst     (n_rst),
        .clear     (clear),
        .write_en  (write_en),
        .data_in   (data_in),
        .read_en   (read_en),
        .data_out  (dout_m),
        .fifo_empty(empty_m),
        .fifo_full (full_m),
        .word_count(cnt_m)
`ifdef FIFO_OUT_ERR_FLAGS_EN
        ,
        .overflow  (ovf_m),
        .underflow (udf_m)
`endif
    );

    block_unpack_fifo #(.BLOCK_W(128), .WORD_W(32), .DEPTH(4), .MSW_FIRST(0)) u_dut_l (
        .clk       (clk),
        .n_rst     (n_rst),
        .clear     (clear),
        .write_en  (write_en),
        .data_in   (data_in),
        .read_en   (read_en),
        .data_out  (dout_l),
        .fifo_empty(empty_l),
        .fifo_full (full_l),
        .word_count(cnt_l)
`ifdef FIFO_OUT_ERR_FLAGS_EN
        ,
        .overflow  (ovf_l),
        .underflow (udf_l)
`endif
    );

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [127:0] blk(input int n);
        logic [7:0] nb;
        nb = n[7:0];
        return {16'hB10C, nb, 8'd0, 16'hB10C, nb, 8'd1, 16'hB10C, nb, 8'd2, 16'hB10C, nb, 8'd3};
    endfunction

    // One clock of stimulus; expectations come from a word-queue model of both read orders.
    task automatic cyc(input bit clr, input bit we, input logic [127:0] din, input bit re);
        int  slots;
        bit  wa, ra;
        slots = (qm.size() + 3) / 4;
        wa = we && !clr && (slots < 4);
        ra = re && !clr && (qm.size() > 0);
`ifdef FIFO_OUT_ERR_FLAGS_EN
        if (clr) begin
            e_ovf = 1'b0;
            e_udf = 1'b0;
        end else begin
            if (we && !wa) e_ovf = 1'b1;
            if (re && !ra) e_udf = 1'b1;
        end
`endif
        clear = clr;
        write_en = we;
        data_in = din;
        read_en = re;
        @(posedge clk);
        #1;
        clear = 1'b0;
        write_en = 1'b0;
        read_en = 1'b0;
        if (clr) begin
            qm.delete();
            ql.delete();
        end
        if (ra) begin
            lm = qm.pop_front();
            ll = ql.pop_front();
        end
        if (wa) begin
            for (int k = 0; k < 4; k++) begin
                qm.push_back(din[127-32*k -: 32]);
                ql.push_back(din[32*k +: 32]);
            end
        end
        check_val("dout_msw", dout_m, lm);
        check_val("dout_lsw", dout_l, ll);
        check_val("count", cnt_m, qm.size());
        check_val("count_lsw", cnt_l, qm.size());
        check_val("empty", empty_m, qm.size() == 0);
        check_val("full", full_m, ((qm.size() + 3) / 4) == 4);
`ifdef FIFO_OUT_ERR_FLAGS_EN
        check_val("overflow", ovf_m, e_ovf);
        check_val("underflow", udf_m, e_udf);
`endif
    endtask

    task automatic model_reset();
        qm.delete();
        ql.delete();
        lm = '0;
        ll = '0;
`ifdef FIFO_OUT_ERR_FLAGS_EN
        e_ovf = 1'b0;
        e_udf = 1'b0;
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_dout"}, dout_m, 32'h0);
        check_val({tag, "_dout_lsw"}, dout_l, 32'h0);
        check_val({tag, "_empty"}, empty_m, 1'b1);
        check_val({tag, "_full"}, full_m, 1'b0);
        check_val({tag, "_count"}, cnt_m, 5'd0);
`ifdef FIFO_OUT_ERR_FLAGS_EN
        check_val({tag, "_ovf"}, ovf_m, 1'b0);
        check_val({tag, "_udf"}, udf_m, 1'b0);
`endif
    endtask

    initial begin
        logic [31:0] exp_m [4];
        logic [31:0] exp_l [4];
        logic [127:0] w;
        int nwr;
        exp_m = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
        exp_l = '{32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233};
        model_reset();

        #1 n_rst = 1'b0;
        #2;
        check_reset_outputs("reset");
        @(posedge clk);
        #1 n_rst = 1'b1;

        // Single block, both word orders.
        cyc(0, 1, Blk, 0);
        check_val("cnt_after_write", cnt_m, 5'd4);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, '0, 1);
            check_val("order_msw", dout_m, exp_m[i]);
            check_val("order_lsw", dout_l, exp_l[i]);
        end
        check_val("empty_after_block", empty_m, 1'b1);
        cyc(0, 0, '0, 0);
        cyc(0, 0, '0, 1);
        check_val("hold_on_empty_read", dout_m, 32'hCCDDEEFF);

        // Fill, overflow, read-last-word with write while full.
        for (int n = 0; n < 4; n++) cyc(0, 1, blk(n), 0);
        check_val("full_after_4", full_m, 1'b1);
        check_val("cnt_full", cnt_m, 5'd16);
        cyc(0, 1, blk(4), 0);
        check_val("cnt_after_drop", cnt_m, 5'd16);
        for (int i = 0; i < 3; i++) cyc(0, 0, '0, 1);
        check_val("b0_word2", dout_m, {16'hB10C, 8'd0, 8'd2});
        cyc(0, 1, blk(5), 1);
        check_val("rdwr_full_dout", dout_m, {16'hB10C, 8'd0, 8'd3});
        check_val("rdwr_full_flag", full_m, 1'b0);
        check_val("rdwr_full_cnt", cnt_m, 5'd12);
        cyc(0, 1, blk(5), 0);
        check_val("refill_full", full_m, 1'b1);

        // Clear overrides write and read and keeps data_out.
        cyc(1, 1, blk(6), 1);
        check_val("clear_cnt", cnt_m, 5'd0);
        check_val("clear_dout_kept", dout_m, {16'hB10C, 8'd0, 8'd3});

        // Read while empty with a concurrent write: only the write lands.
        cyc(0, 1, blk(7), 1);
        check_val("empty_rdwr_cnt", cnt_m, 5'd4);
        for (int i = 0; i < 4; i++) cyc(0, 0, '0, 1);
        check_val("b7_word3", dout_m, {16'hB10C, 8'd7, 8'd3});

        // Concurrent read/write with pointer wrap over 9 blocks.
        cyc(0, 1, blk(10), 0);
        cyc(0, 1, blk(11), 0);
        cyc(0, 0, '0, 1);
        check_val("cnt_7", cnt_m, 5'd7);
        cyc(0, 1, blk(12), 1);
        check_val("cnt_10", cnt_m, 5'd10);
        nwr = 3;
        for (int c = 0; c < 40; c++) begin
            if ((c % 4 == 0) && (nwr < 9)) begin
                w = blk(10 + nwr);
                nwr++;
                cyc(0, 1, w, 1);
            end else begin
                cyc(0, 0, '0, 1);
            end
        end
        check_val("wrap_last_word", dout_m, {16'hB10C, 8'd18, 8'd3});
        check_val("wrap_empty", empty_m, 1'b1);

        // Asynchronous reset mid-block.
        cyc(0, 1, Blk, 0);
        cyc(0, 0, '0, 1);
        cyc(0, 0, '0, 1);
        #3 n_rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        @(posedge clk);
        #1 n_rst = 1'b1;
        cyc(0, 1, blk(20), 0);
        cyc(0, 0, '0, 1);
        check_val("post_reset_w0", dout_m, {16'hB10C, 8'd20, 8'd0});
        check_val("post_reset_w0_lsw", dout_l, {16'hB10C, 8'd20, 8'd3});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
